// File: rtl/mips_multicycle_control_if.sv
// Control interface between the multicycle MIPS controller (master) and the datapath (slave).
// The master receives the opcode, funct and zero flag, and drives every datapath strobe.
interface mips_multicycle_control_if;
  logic [5:0] OP_i;
  logic [5:0] Funct_i;
  logic       ZERO_i;
  logic       IorD_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       RegDst_o;
  logic       MemtoReg_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic       PCSrc_o;
  logic       PCEn_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALUControl_o;
  logic [3:0] State_o;
  logic       Illegal_o;

  modport master (
    input  OP_i, Funct_i, ZERO_i,
    output IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
           ALUSrcA_o, PCSrc_o, PCEn_o, ALUSrcB_o, ALUControl_o, State_o, Illegal_o
  );

  modport slave (
    output OP_i, Funct_i, ZERO_i,
    input  IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
           ALUSrcA_o, PCSrc_o, PCEn_o, ALUSrcB_o, ALUControl_o, State_o, Illegal_o
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (R-type, lw, sw, beq, addi); Moore strobes except PCEn.
// Optional macro CTRL_BNE_EN adds bne (opcode 6'h05) sharing the BRANCH state.
module mips_multicycle_control (
  input  logic                              clk,
  input  logic                              reset,
  mips_multicycle_control_if.master         ctrl
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;

  logic [3:0] state_q, state_d;

  logic       is_bne;
  logic       op_legal;
  logic       branch_cond;
  logic [2:0] funct_alu;
  logic       funct_ok;

  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_src, pc_write, branch, illegal;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;

`ifdef CTRL_BNE_EN
  assign is_bne      = (ctrl.OP_i == OP_BNE);
  assign branch_cond = is_bne ? ~ctrl.ZERO_i : ctrl.ZERO_i;
`else
  assign is_bne      = 1'b0;
  assign branch_cond = ctrl.ZERO_i;
`endif

  assign op_legal = (ctrl.OP_i == OP_LW)  || (ctrl.OP_i == OP_SW)  ||
                    (ctrl.OP_i == OP_RTYPE) || (ctrl.OP_i == OP_BEQ) ||
                    (ctrl.OP_i == OP_ADDI) || is_bne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if ((ctrl.OP_i == OP_LW) || (ctrl.OP_i == OP_SW)) state_d = S_MEMADR;
        else if (ctrl.OP_i == OP_RTYPE)                  state_d = S_EXEC;
        else if ((ctrl.OP_i == OP_BEQ) || is_bne)         state_d = S_BRANCH;
        else if (ctrl.OP_i == OP_ADDI)                    state_d = S_ADDIEX;
        else                                              state_d = S_FETCH;
      end
      S_MEMADR: state_d = (ctrl.OP_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      // Writeback/terminal states and unused codes 11-15 all restart at FETCH.
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (ctrl.Funct_i)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    pc_src      = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        illegal     = ~funct_ok;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 1'b1;
        branch      = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  // Write enables are gated by reset directly so nothing commits while reset is held.
  assign ctrl.IorD_o       = iord;
  assign ctrl.MemWrite_o   = mem_write & reset;
  assign ctrl.IRWrite_o    = ir_write & reset;
  assign ctrl.RegDst_o     = reg_dst;
  assign ctrl.MemtoReg_o   = mem_to_reg;
  assign ctrl.RegWrite_o   = reg_write & reset;
  assign ctrl.ALUSrcA_o    = alu_src_a;
  assign ctrl.PCSrc_o      = pc_src;
  assign ctrl.PCEn_o       = (pc_write | (branch & branch_cond)) & reset;
  assign ctrl.ALUSrcB_o    = alu_src_b;
  assign ctrl.ALUControl_o = alu_control;
  assign ctrl.State_o      = state_q;
  assign ctrl.Illegal_o    = illegal & reset;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control: each task walks one instruction
// through the FSM, sampling outputs on the falling edge.
module tb_mips_multicycle_control;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.State_o); end
      checks++; if (bus.IRWrite_o !== 1'b0) begin errors++; $display("FAIL rst_irwrite got=%b exp=0", bus.IRWrite_o); end
      checks++; if (bus.PCEn_o !== 1'b0) begin errors++; $display("FAIL rst_pcen got=%b exp=0", bus.PCEn_o); end
      checks++; if (bus.ALUSrcB_o !== 2'b01) begin errors++; $display("FAIL rst_alusrcb got=%b exp=01", bus.ALUSrcB_o); end
    end
    reset = 1'b1;
    #1;
    checks++; if (bus.IRWrite_o !== 1'b1) begin errors++; $display("FAIL rel_irwrite got=%b exp=1", bus.IRWrite_o); end
    checks++; if (bus.PCEn_o !== 1'b1) begin errors++; $display("FAIL rel_pcen got=%b exp=1", bus.PCEn_o); end
    checks++; if (bus.ALUSrcB_o !== 2'b01) begin errors++; $display("FAIL rel_alusrcb got=%b exp=01", bus.ALUSrcB_o); end
    $display("reset: released into FETCH state=%0d", bus.State_o);
  endtask

  task automatic test_lw();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    bus.OP_i = 6'h23;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.State_o !== seq[i]) begin errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.State_o, seq[i]); end
      if (i == 1) begin
        checks++; if (bus.ALUSrcB_o !== 2'b11) begin errors++; $display("FAIL lw_dec_alusrcb got=%b exp=11", bus.ALUSrcB_o); end
        checks++; if (bus.PCEn_o !== 1'b0) begin errors++; $display("FAIL lw_dec_pcen got=%b exp=0", bus.PCEn_o); end
      end
      if (i == 2) begin
        checks++; if ({bus.ALUSrcA_o, bus.ALUSrcB_o} !== 3'b110) begin errors++; $display("FAIL lw_madr_src got=%b exp=110", {bus.ALUSrcA_o, bus.ALUSrcB_o}); end
      end
      if (i == 3) begin
        checks++; if (bus.IorD_o !== 1'b1) begin errors++; $display("FAIL lw_memrd_iord got=%b exp=1", bus.IorD_o); end
      end
      if (i == 4) begin
        checks++; if ({bus.RegWrite_o, bus.MemtoReg_o, bus.RegDst_o} !== 3'b110) begin errors++; $display("FAIL lw_memwb got=%b exp=110", {bus.RegWrite_o, bus.MemtoReg_o, bus.RegDst_o}); end
      end
      if (i < 5) @(negedge clk);
    end
    $display("lw: 5-cycle sequence walked");
  endtask

  task automatic test_rtype();
    logic [5:0] functs [5];
    logic [2:0] alus   [5];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    alus   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int k = 0; k < 5; k++) begin
      bus.OP_i    = 6'h00;
      bus.Funct_i = functs[k];
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.State_o !== 4'd6) begin errors++; $display("FAIL rt_exec_state f=%h got=%0d exp=6", functs[k], bus.State_o); end
      checks++; if (bus.ALUControl_o !== alus[k]) begin errors++; $display("FAIL rt_aluctl f=%h got=%b exp=%b", functs[k], bus.ALUControl_o, alus[k]); end
      checks++; if ({bus.ALUSrcA_o, bus.ALUSrcB_o, bus.Illegal_o} !== 4'b1000) begin errors++; $display("FAIL rt_exec_src f=%h got=%b exp=1000", functs[k], {bus.ALUSrcA_o, bus.ALUSrcB_o, bus.Illegal_o}); end
      @(negedge clk);
      checks++; if ({bus.State_o, bus.RegDst_o, bus.RegWrite_o, bus.MemtoReg_o} !== 7'b0111110) begin errors++; $display("FAIL rt_aluwb f=%h got=%b exp=0111110", functs[k], {bus.State_o, bus.RegDst_o, bus.RegWrite_o, bus.MemtoReg_o}); end
      @(negedge clk);
      checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL rt_back_fetch f=%h got=%0d exp=0", functs[k], bus.State_o); end
      $display("rtype: funct=%h alu=%b", functs[k], bus.ALUControl_o);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      bus.OP_i   = 6'h04;
      bus.ZERO_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.State_o !== 4'd1) begin errors++; $display("FAIL beq_dec z=%0d got=%0d exp=1", z, bus.State_o); end
      bus.ZERO_i = z[0];
      @(negedge clk);
      checks++; if (bus.State_o !== 4'd8) begin errors++; $display("FAIL beq_state z=%0d got=%0d exp=8", z, bus.State_o); end
      checks++; if (bus.PCEn_o !== z[0]) begin errors++; $display("FAIL beq_pcen z=%0d got=%b exp=%b", z, bus.PCEn_o, z[0]); end
      checks++; if ({bus.PCSrc_o, bus.ALUControl_o, bus.ALUSrcA_o} !== 5'b11101) begin errors++; $display("FAIL beq_ctl z=%0d got=%b exp=11101", z, {bus.PCSrc_o, bus.ALUControl_o, bus.ALUSrcA_o}); end
      bus.ZERO_i = ~z[0];
      #1;
      checks++; if (bus.PCEn_o !== ~z[0]) begin errors++; $display("FAIL beq_pcen_comb z=%0d got=%b exp=%b", z, bus.PCEn_o, ~z[0]); end
      bus.ZERO_i = z[0];
      @(negedge clk);
      checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL beq_next z=%0d got=%0d exp=0", z, bus.State_o); end
      $display("beq: zero=%0d handled", z);
    end
    bus.ZERO_i = 1'b0;
  endtask

  task automatic test_sw_addi();
    bus.OP_i = 6'h2B;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.State_o !== 4'd5) begin errors++; $display("FAIL sw_state got=%0d exp=5", bus.State_o); end
    checks++; if ({bus.MemWrite_o, bus.IorD_o, bus.RegWrite_o} !== 3'b110) begin errors++; $display("FAIL sw_memwr got=%b exp=110", {bus.MemWrite_o, bus.IorD_o, bus.RegWrite_o}); end
    @(negedge clk);
    checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL sw_next got=%0d exp=0", bus.State_o); end
    $display("sw: MEMWR strobes checked");
    bus.OP_i = 6'h08;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.State_o, bus.ALUSrcA_o, bus.ALUSrcB_o} !== 7'b1001110) begin errors++; $display("FAIL addi_ex got=%b exp=1001110", {bus.State_o, bus.ALUSrcA_o, bus.ALUSrcB_o}); end
    @(negedge clk);
    checks++; if ({bus.State_o, bus.RegWrite_o, bus.RegDst_o, bus.MemtoReg_o} !== 7'b1010100) begin errors++; $display("FAIL addi_wb got=%b exp=1010100", {bus.State_o, bus.RegWrite_o, bus.RegDst_o, bus.MemtoReg_o}); end
    @(negedge clk);
    checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL addi_next got=%0d exp=0", bus.State_o); end
    $display("addi: 4-cycle sequence walked");
  endtask

  task automatic test_illegal();
    bus.OP_i = 6'h3F;
    checks++; if (bus.Illegal_o !== 1'b0) begin errors++; $display("FAIL ill_fetch got=%b exp=0", bus.Illegal_o); end
    @(negedge clk);
    checks++; if ({bus.State_o, bus.Illegal_o} !== 5'b00011) begin errors++; $display("FAIL ill_dec got=%b exp=00011", {bus.State_o, bus.Illegal_o}); end
    @(negedge clk);
    checks++; if ({bus.State_o, bus.Illegal_o} !== 5'b00000) begin errors++; $display("FAIL ill_after got=%b exp=00000", {bus.State_o, bus.Illegal_o}); end
    $display("illegal: opcode 3F pulse checked");
    bus.OP_i = 6'h05;
    @(negedge clk);
`ifdef CTRL_BNE_EN
    checks++; if ({bus.State_o, bus.Illegal_o} !== 5'b00010) begin errors++; $display("FAIL bne_dec got=%b exp=00010", {bus.State_o, bus.Illegal_o}); end
    @(negedge clk);
    checks++; if ({bus.State_o, bus.PCEn_o} !== 5'b10001) begin errors++; $display("FAIL bne_branch got=%b exp=10001", {bus.State_o, bus.PCEn_o}); end
`else
    checks++; if ({bus.State_o, bus.Illegal_o} !== 5'b00011) begin errors++; $display("FAIL bne_illegal got=%b exp=00011", {bus.State_o, bus.Illegal_o}); end
`endif
    @(negedge clk);
    checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL bne_next got=%0d exp=0", bus.State_o); end
    $display("bne: opcode 05 checked");
    bus.OP_i    = 6'h00;
    bus.Funct_i = 6'h3F;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.State_o, bus.Illegal_o, bus.ALUControl_o} !== 8'b01101010) begin errors++; $display("FAIL funct_ill got=%b exp=01101010", {bus.State_o, bus.Illegal_o, bus.ALUControl_o}); end
    @(negedge clk);
    checks++; if ({bus.State_o, bus.RegWrite_o, bus.Illegal_o} !== 6'b011110) begin errors++; $display("FAIL funct_ill_wb got=%b exp=011110", {bus.State_o, bus.RegWrite_o, bus.Illegal_o}); end
    @(negedge clk);
    bus.Funct_i = 6'h20;
    $display("illegal: funct 3F pulse checked");
  endtask

  task automatic test_abort();
    bus.OP_i = 6'h2B;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.State_o, bus.MemWrite_o} !== 5'b01011) begin errors++; $display("FAIL abort_pre got=%b exp=01011", {bus.State_o, bus.MemWrite_o}); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({bus.State_o, bus.MemWrite_o, bus.IorD_o} !== 6'b000000) begin errors++; $display("FAIL abort_now got=%b exp=000000", {bus.State_o, bus.MemWrite_o, bus.IorD_o}); end
    checks++; if ({bus.IRWrite_o, bus.PCEn_o, bus.RegWrite_o, bus.Illegal_o} !== 4'b0000) begin errors++; $display("FAIL abort_en got=%b exp=0000", {bus.IRWrite_o, bus.PCEn_o, bus.RegWrite_o, bus.Illegal_o}); end
    @(negedge clk);
    checks++; if (bus.State_o !== 4'd0) begin errors++; $display("FAIL abort_hold got=%0d exp=0", bus.State_o); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.State_o !== 4'd1) begin errors++; $display("FAIL abort_restart got=%0d exp=1", bus.State_o); end
    $display("abort: reset during MEMWR checked");
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    bus.OP_i    = 6'h00;
    bus.Funct_i = 6'h20;
    bus.ZERO_i  = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_addi();
    test_illegal();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle MIPS control FSM: the driving end of the datapath control interface.
- Consumes OP/Funct/ZERO from the datapath; produces every datapath control strobe (IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, PCEn, ALUSrcB, ALUControl).
- Instantiated beside the datapath in the processor top.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
OP_i  input  6  instruction opcode from datapath
Funct_i  input  6  R-type funct field from datapath
ZERO_i  input  1  ALU zero flag from datapath
IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, PCSrc_o, PCEn_o  output  1 each  datapath strobes
ALUSrcB_o  output  2  ALU B-operand select (00 reg, 01 const 4, 10 signimm, 11 signimm<<2)
ALUControl_o  output  3  ALU op (010 add, 110 sub, 000 and, 001 or, 111 slt)
State_o  output  4  current state, scope/debug
Illegal_o  output  1  one-cycle pulse on unsupported opcode or funct

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low.
- State register: 4 bits, async active-low reset to FETCH.
- Outputs are Moore decodes of the state. The only exception is PCEn_o = PCWrite | (Branch & ZERO_i), combinational on ZERO_i.
- While reset==0:
  - State_o=0 (FETCH).
  - MemWrite_o, IRWrite_o, RegWrite_o, PCEn_o and Illegal_o are forced to 0.
  - All other outputs take their FETCH values.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10. Codes 11-15 go to FETCH on the next edge.
- Per-state outputs (unlisted 1-bit outputs are 0, ALUSrcB=00, ALUControl=010):
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, IRWrite=1, PCWrite=1, PCSrc=0.
  - DECODE: ALUSrcA=0, ALUSrcB=11.
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct_i.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=1, Branch=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on OP_i:
    - LW or SW -> MEMADR.
    - RTYPE -> EXEC.
    - BEQ -> BRANCH.
    - ADDI -> ADDIEX.
    - any other opcode -> FETCH, with Illegal_o=1 during DECODE.
  - MEMADR -> MEMRD if OP_i==LW, else MEMWR.
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH and ADDIWB -> FETCH.
- Funct decode in EXEC:
  - 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111.
  - Any other funct -> ALUControl 010 and Illegal_o=1 in EXEC; ALUWB still follows (register write is not suppressed).
- Instruction latency, FETCH to next FETCH: lw 5 cycles; sw, R-type and addi 4; beq 3.
- OP_i and Funct_i are sampled in the states above only. The datapath instruction register holds them stable after FETCH.
- Reset asserted mid-instruction: state returns to FETCH immediately and the enables drop the same instant. There are no partial writes after the reset edge.

Optional Feature:
- Macro: CTRL_BNE_EN.
- When defined:
  - Opcode 6'h05 (bne) in DECODE -> BRANCH.
  - The BRANCH strobe qualifies on ~ZERO_i for bne, on ZERO_i for beq: PCEn_o = PCWrite | (Branch & (isBNE ? ~ZERO_i : ZERO_i)).
  - isBNE is decoded from OP_i held in the instruction register.
- When undefined: 6'h05 is illegal (Illegal_o pulse, return to FETCH).

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> State_o=0, IRWrite_o=PCEn_o=0 during reset. The first edge after release gives IRWrite_o=1 and PCEn_o=1 with ALUSrcB_o=01.
- lw: OP_i=6'h23 -> State_o sequence 0,1,2,3,4,0. MEMRD has IorD_o=1. MEMWB has RegWrite_o=1, MemtoReg_o=1.
- R-type: OP_i=0, Funct_i=6'h2A -> EXEC shows ALUControl_o=111, ALUSrcA_o=1. ALUWB shows RegDst_o=1, RegWrite_o=1. 4 cycles total.
- beq: OP_i=6'h04 with ZERO_i=1 -> PCEn_o=1 and PCSrc_o=1 in BRANCH. Repeat with ZERO_i=0 -> PCEn_o=0. Next state FETCH both times.
- sw then addi: OP_i=6'h2B -> MEMWR has MemWrite_o=1, IorD_o=1. OP_i=6'h08 -> ADDIEX has ALUSrcB_o=10; ADDIWB has RegWrite_o=1, RegDst_o=0.
- Illegal and abort cases:
  - OP_i=6'h3F -> Illegal_o one-cycle pulse in DECODE, then FETCH.
  - reset=0 asserted during MEMWR -> MemWrite_o drops to 0 immediately, State_o=0.
